// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the sequential ALU.
// The opcode values match the original 2-bit combinational ALU.
package alu_pkg;

  localparam logic [1:0] OP_ZERO = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] MUL  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add unsigned multiplier: one multiplier bit per cycle, LSB first.
// done is raised during the final iteration, and product already includes that iteration's add.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               active_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] addend_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic               last_s;

  // Partial product for the current iteration.
  always_comb begin
    addend_s   = {(2*WIDTH){1'b0}};
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {(2*WIDTH){1'b0}};
    end
    acc_next_s = acc_r + addend_s;
    last_s     = active_r && (cnt_r == CW'(WIDTH - 1));
  end

  assign done    = last_s;
  assign product = acc_next_s;

  // Iteration state; reset discards any partial product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
    end else if (start) begin
      active_r <= 1'b1;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
    end else if (active_r) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
      active_r <= !last_s;
    end else begin
      active_r <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: zero/add/sub complete in one cycle, multiply runs through seq_multiplier.
// Control outputs are decoded purely from the registered state.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  logic [1:0]         state_r;
  logic [2*WIDTH-1:0] result_r;
  logic               accept_s;
  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_product_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [2*WIDTH-1:0] simple_res_s;

  assign in_ready    = (state_r == IDLE);
  assign out_valid   = (state_r == DONE);
  assign busy        = (state_r != IDLE);
  assign result      = result_r;
  assign accept_s    = in_valid && (state_r == IDLE);
  assign mul_start_s = accept_s && (op == OP_MUL);

  // Single-cycle ops; the extra top bit of diff_s is the borrow.
  always_comb begin
    sum_s        = {1'b0, x} + {1'b0, y};
    diff_s       = {1'b0, x} - {1'b0, y};
    simple_res_s = {(2*WIDTH){1'b0}};
    case (op)
      OP_ZERO: simple_res_s = {(2*WIDTH){1'b0}};
      OP_ADD:  simple_res_s = {{(WIDTH-1){1'b0}}, sum_s};
      OP_SUB:  simple_res_s = {{(WIDTH-1){1'b0}}, diff_s};
      default: simple_res_s = {(2*WIDTH){1'b0}};
    endcase
  end

  seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (x),
    .b       (y),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // Control FSM; result only loads on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      result_r <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (op == OP_MUL) begin
              state_r <= MUL;
            end else begin
              state_r  <= DONE;
              result_r <= simple_res_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MUL: begin
          if (mul_done_s) begin
            state_r  <= DONE;
            result_r <= mul_product_s;
          end else begin
            state_r <= MUL;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
